// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, default width and Q_LSB patterns for the Booth controller
package booth_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, OP, SHIFT, DONE} booth_state_t;
  localparam int BOOTH_N = 8;
  localparam logic [1:0] QLSB_ADD = 2'b01;
  localparam logic [1:0] QLSB_SUB = 2'b10;
endpackage

// File: rtl/booth_iter_cnt.sv
// booth_iter_cnt: loadable iteration down-counter with a last-iteration flag
//   clk, rst (async, active-low), load (set count to N), dec (count down), last (count == 1)
module booth_iter_cnt #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);
  localparam int W = $clog2(N) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= W'(N);
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == W'(1);
endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequencing FSM for the radix-2 Booth multiplier datapath
//   in : clk, rst (async, active-low), start, Q_LSB = {Q[0], Q_-1}
//   out: load_A, load_B, load_add, add_sub (1 = subtract), shift_HQ_LQ_Q_1, busy, ready
//   BOOTH_EARLY_SHIFT_EN: shift directly in OP when no add/sub is needed, skipping SHIFT
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int N = BOOTH_N
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Q_LSB,
  output logic       load_A,
  output logic       load_B,
  output logic       load_add,
  output logic       add_sub,
  output logic       shift_HQ_LQ_Q_1,
  output logic       busy,
  output logic       ready
);
  booth_state_t state, nxt;
  logic last, op_req;
  booth_iter_cnt #(.N(N)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(state == LOAD),
    .dec (shift_HQ_LQ_Q_1),
    .last(last)
  );
  assign op_req = (Q_LSB == QLSB_ADD) || (Q_LSB == QLSB_SUB);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    load_A = 1'b0;
    load_B = 1'b0;
    load_add = 1'b0;
    add_sub = 1'b0;
    shift_HQ_LQ_Q_1 = 1'b0;
    ready = 1'b0;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: begin
        load_A = 1'b1;
        load_B = 1'b1;
        nxt = OP;
      end
      OP: begin
        load_add = op_req;
        add_sub = Q_LSB == QLSB_SUB;
`ifdef BOOTH_EARLY_SHIFT_EN
        shift_HQ_LQ_Q_1 = !op_req;
        nxt = op_req ? SHIFT : (last ? DONE : OP);
`else
        nxt = SHIFT;
`endif
      end
      SHIFT: begin
        shift_HQ_LQ_Q_1 = 1'b1;
        nxt = last ? DONE : OP;
      end
      DONE: begin
        ready = 1'b1;
        nxt = start ? LOAD : DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign busy = (state == LOAD) || (state == OP) || (state == SHIFT);
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: scoreboard bench driving the controller against a behavioural Booth datapath
module tb_booth_mult_ctrl;
  localparam int N = 8;
  typedef struct {
    logic [2*N-1:0] y;
    int c0;
    int lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0] Q_LSB;
  logic load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1, busy, ready;
  logic [N-1:0] a_in = '0, b_in = '0, m;
  logic signed [N:0] hq;
  logic [N-1:0] q;
  logic q1;
  logic [2*N-1:0] y;
  int cyc = 0, vectors = 0, miscompares = 0;
  exp_t sb[$];
  booth_mult_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .Q_LSB(Q_LSB),
    .load_A(load_A), .load_B(load_B), .load_add(load_add), .add_sub(add_sub),
    .shift_HQ_LQ_Q_1(shift_HQ_LQ_Q_1), .busy(busy), .ready(ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (load_A) m <= a_in;
    if (load_B) begin
      q <= b_in;
      hq <= '0;
      q1 <= 1'b0;
    end else if (load_add) hq <= add_sub ? hq - $signed({m[N-1], m}) : hq + $signed({m[N-1], m});
    else if (shift_HQ_LQ_Q_1) {hq, q, q1} <= {hq[N], hq, q};
  end
  assign Q_LSB = {q[0], q1};
  assign y = {hq[N-1:0], q};
  function automatic logic [2*N-1:0] ref_y(logic [N-1:0] a, logic [N-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*N-1:0];
  endfunction
  function automatic int ref_lat(logic [N-1:0] b);
    int ops = 0;
    logic prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (b[i] != prev) ops++;
      prev = b[i];
    end
`ifdef BOOTH_EARLY_SHIFT_EN
    return 2 + N + ops;
`else
    return 2 * N + 2 + 0 * ops;
`endif
  endfunction
  task automatic chk(string name, longint act, longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic launch(logic [N-1:0] a, logic [N-1:0] b);
    @(posedge clk);
    #1;
    a_in = a;
    b_in = b;
    start = 1'b1;
    sb.push_back('{ref_y(a, b), cyc, ref_lat(b)});
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic poke_start(int r);
    repeat (r) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
    chk("done_timeout", sb.size(), 0);
  endtask
  initial begin : monitor
    int shifts = 0;
    logic prev_ready = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        shifts = 0;
        prev_ready = 1'b0;
      end else begin
        if (shift_HQ_LQ_Q_1) shifts++;
        if (load_A) begin
          shifts = 0;
          chk("ready_in_load", ready, 0);
          chk("busy_in_load", busy, 1);
        end
        if (!load_add && add_sub) chk("add_sub_without_load_add", add_sub, 0);
        if (ready && !prev_ready) begin
          if (sb.size() == 0) chk("unexpected_ready", 1, 0);
          else begin
            e = sb.pop_front();
            chk("product", y, e.y);
            chk("ready_latency", cyc - e.c0, e.lat);
            chk("shift_pulses", shifts, N);
            chk("busy_in_done", busy, 0);
          end
        end
        prev_ready = ready;
      end
    end
  end
  initial begin
    #2 chk("reset_outputs", {load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1, busy, ready}, 0);
    #20 rst = 1'b1;
    launch(8'd3, 8'd5);
    wait_done();
    launch(8'hFD, 8'd5);
    wait_done();
    launch(8'h80, 8'h80);
    wait_done();
    launch(8'd3, 8'd5);
    poke_start(5);
    wait_done();
    repeat (40) @(posedge clk);
    #1 chk("no_relaunch_from_busy_start", ready, 1);
    launch(8'd11, 8'hF3);
    wait_done();
    launch(8'h55, 8'd3);
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1, busy, ready}, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    launch(8'd7, 8'd6);
    wait_done();
    launch(8'd9, 8'd0);
    wait_done();
    launch(8'd9, 8'd1);
    wait_done();
    for (int i = 0; i < 24; i++) begin
      launch(N'($urandom), N'($urandom));
      if ($urandom_range(2) == 0) poke_start($urandom_range(N - 1));
      wait_done();
      repeat ($urandom_range(3)) @(posedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
